// File: rtl/pipe_fetch_reg.sv
// Fetch-stage register block: PC register, instruction-memory request and IF/ID register.
// Define PIPE_FETCH_SKID_EN to add the skid buffer and HOLD state; otherwise stalled words are re-fetched.
module pipe_fetch_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic [31:0] pc4,
    output logic [31:0] pc,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall_id,
    input  logic        flush,
    output logic        if_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    // state | meaning
    // RUN   | request outstanding or being issued at pc
    // HOLD  | word parked in skid buffer, waiting for decode to accept it
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic ld_id_mem;
    logic bubble_id;
    logic adv_pc;

`ifdef PIPE_FETCH_SKID_EN
    logic        ld_skid;
    logic        ld_id_skid;
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] skid_pc4;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
`ifdef PIPE_FETCH_SKID_EN
                    if (imem_ready && stall_id) begin
                        state_nxt = ST_HOLD;
                    end
`else
                    state_nxt = ST_RUN;
`endif
                end
`ifdef PIPE_FETCH_SKID_EN
                ST_HOLD: begin
                    if (!stall_id) begin
                        state_nxt = ST_RUN;
                    end
                end
`endif
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_comb begin
        imem_req  = (state == ST_RUN) && !rst;
        ld_id_mem = 1'b0;
        bubble_id = 1'b0;
        adv_pc    = 1'b0;
`ifdef PIPE_FETCH_SKID_EN
        ld_skid    = 1'b0;
        ld_id_skid = 1'b0;
`endif
        // A flush cycle discards whatever memory returns.
        if (!flush) begin
            case (state)
                ST_RUN: begin
                    if (imem_ready) begin
                        if (!stall_id) begin
                            ld_id_mem = 1'b1;
                            adv_pc    = 1'b1;
                        end else begin
`ifdef PIPE_FETCH_SKID_EN
                            ld_skid = 1'b1;
`endif
                        end
                    end else if (!stall_id) begin
                        bubble_id = 1'b1;
                    end
                end
`ifdef PIPE_FETCH_SKID_EN
                ST_HOLD: begin
                    if (!stall_id && skid_valid) begin
                        ld_id_skid = 1'b1;
                        adv_pc     = 1'b1;
                    end
                end
`endif
                default: begin
                    bubble_id = 1'b0;
                end
            endcase
        end
    end

    assign if_stall = imem_req && !imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= '0;
            id_pc4   <= '0;
        end else begin
            if (flush || adv_pc) begin
                pc <= next_pc;
            end
            // Bubbles keep id_pc/id_pc4 so decode sees stable payload bits.
            if (flush || bubble_id) begin
                id_valid <= 1'b0;
                id_inst  <= NOP_INST;
            end else if (ld_id_mem) begin
                id_valid <= 1'b1;
                id_inst  <= imem_rdata;
                id_pc    <= pc;
                id_pc4   <= pc4;
            end
`ifdef PIPE_FETCH_SKID_EN
            else if (ld_id_skid) begin
                id_valid <= 1'b1;
                id_inst  <= skid_inst;
                id_pc    <= skid_pc;
                id_pc4   <= skid_pc4;
            end
`endif
        end
    end

`ifdef PIPE_FETCH_SKID_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            skid_valid <= 1'b0;
        end else if (ld_skid) begin
            skid_valid <= 1'b1;
        end else if (ld_id_skid) begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_skid) begin
            skid_inst <= imem_rdata;
            skid_pc   <= pc;
            skid_pc4  <= pc4;
        end
    end
`endif

endmodule

// File: doc/pipe_fetch_reg.md
# pipe_fetch_reg

Fetch-stage register block: holds the program counter, issues instruction-memory requests, and loads the IF/ID pipeline register. It closes the loop around the combinational next-PC selector. `pc` feeds the selector, and the selector's `next_pc`/`pc4` come back here. It absorbs memory wait states, downstream stalls and redirect flushes, and presents a valid-tagged instruction to decode.

## Interface
- `RESET_PC`, default 32'h0000_0000 — PC value after reset.
- `NOP_INST`, default 32'h0000_0000 — instruction word driven on `id_inst` when the slot is a bubble.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `next_pc` in 32 — PC selected for the next fetch (from next-PC selector).
- `pc4` in 32 — `pc + 4` from the next-PC selector.
- `pc` out 32 — current fetch PC; also the memory address.
- `imem_req` out 1 — fetch request for address `pc`.
- `imem_rdata` in 32 — instruction word, valid when `imem_ready` = 1.
- `imem_ready` in 1 — memory has returned the word for the current `pc`.
- `stall_id` in 1 — decode cannot accept a new instruction this cycle.
- `flush` in 1 — redirect; kill the IF/ID contents and any buffered word.
- `if_stall` out 1 — fetch is waiting on memory (`imem_req` & !`imem_ready`).
- `id_valid` out 1 — IF/ID holds a real instruction.
- `id_inst` out 32, `id_pc` out 32, `id_pc4` out 32 — IF/ID payload.

## Operation
- States: RUN (request outstanding or issuing) and HOLD (word captured in skid buffer, waiting for decode).
- `imem_req` = (state == RUN) & !rst. This is combinational from state, with no registered delay.
- RUN, `imem_ready`=1, `stall_id`=0:
  - IF/ID ← {1, `imem_rdata`, `pc`, `pc4`}.
  - `pc` ← `next_pc`.
  - Stay in RUN.
- RUN, `imem_ready`=1, `stall_id`=1:
  - Skid buffer ← {`imem_rdata`, `pc`, `pc4`}.
  - IF/ID holds.
  - `pc` holds.
  - Go to HOLD.
- RUN, `imem_ready`=0:
  - If `stall_id`=0, IF/ID ← bubble (`id_valid`=0, `id_inst`=NOP_INST, `id_pc`/`id_pc4` hold).
  - If `stall_id`=1, IF/ID holds.
  - `pc` holds.
- HOLD, `stall_id`=1: everything holds and `imem_req`=0.
- HOLD, `stall_id`=0:
  - IF/ID ← {1, buffer}.
  - `pc` ← `next_pc`.
  - Go to RUN.
- `flush`=1 overrides all of the above, regardless of `stall_id`, `imem_ready` or state:
  - `id_valid` ← 0 and `id_inst` ← NOP_INST.
  - Skid buffer is invalidated.
  - `pc` ← `next_pc`, which is the redirect target presented by the selector in the same cycle.
  - State ← RUN.
  - The word returned in a flush cycle is discarded.
- Arithmetic: none locally; `pc4` is taken from the input, not recomputed. PC wrap-around at 32'hFFFF_FFFC follows `next_pc` unchanged.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `pc`=RESET_PC, state=RUN.
  - `id_valid`=0, `id_inst`=NOP_INST, `id_pc`=0, `id_pc4`=0.
  - Skid buffer invalid.
  - `imem_req`=0 while `rst`=1.
- Reset asserted mid-HOLD or mid-wait drops the buffered word. The first request after release is to RESET_PC.
- Zero-wait memory gives one instruction per cycle. Latency is 1 cycle from `imem_ready` to `id_valid`.
- `if_stall` is combinational and asserts in the same cycle as the unanswered request.
- `stall_id` and `flush` are sampled at the clock edge. Flush takes effect on IF/ID in the next cycle, so the slot becomes a bubble.

## Configuration
- `PIPE_FETCH_SKID_EN` defined: skid buffer and HOLD state are present, as described above.
- Undefined: no buffer and no HOLD state. In RUN with `imem_ready`=1 and `stall_id`=1, the word is dropped and `pc` holds. The same address is re-requested each cycle until decode accepts it.
- Externally visible ordering of `id_*` is identical with and without the macro; only `imem_req` traffic differs.

## Test plan
- Reset with RESET_PC=32'h0000_1000, `imem_ready` tied 1, `next_pc`=`pc4`=`pc`+4:
  - First `id_pc`=32'h1000 with `id_valid`=1 one cycle after release.
  - Then 32'h1004, 32'h1008 on consecutive cycles.
- `imem_ready` low for 3 cycles at `pc`=32'h1008:
  - `if_stall`=1 for 3 cycles.
  - 3 bubbles (`id_valid`=0, `id_inst`=NOP_INST).
  - `pc` stays 32'h1008, then `id_pc`=32'h1008.
- `stall_id`=1 for 2 cycles coincident with `imem_ready` at 32'h100C:
  - With the macro: HOLD entered, `imem_req`=0 for 2 cycles, then `id_inst`=buffered word and `id_pc`=32'h100C.
  - Without the macro: 32'h100C is re-requested and delivered after the stall.
- `flush`=1 with `next_pc`=32'h2000 while in HOLD: `id_valid`=0 next cycle, buffer dropped, `pc`=32'h2000, state RUN.
- `flush`=1 and `stall_id`=1 in the same cycle: flush wins, so `id_valid`=0 and `pc` ← `next_pc`.
- `rst` pulsed while `imem_ready`=0 with `pc`=32'h2008: `pc`=RESET_PC and all `id_*` outputs at reset values the next cycle.
